// File: rtl/pep_ks_ctrl_cmd_gen.sv
// pep_ks_ctrl_cmd_gen
// Buffers batch commands from the sequencer in a small FIFO and expands each
// one into KS_BLOCK_COL_NB per-column process commands for the KS feed stage.
// Acknowledges each command to the sequencer once its last column is handed off.
//
// Ports
//   clk, a_rst          : clock, asynchronous active-high reset
//   reset_cache         : synchronous flush request (registered internally)
//   seq_cmd_*           : incoming batch command (valid/ready)
//   feed_pcmd_*         : registered per-column process command
//   feed_vld/feed_rdy   : process command handshake
//   seq_ack*            : one-cycle completion pulse with the batch slot
//
// state | meaning
// IDLE  | no command presented; loads FIFO head (or bypasses a fresh push)
// RUN   | presenting a command; ks_loop advances on each accepted column

module pep_ks_ctrl_cmd_gen #(
  parameter int KS_BLOCK_COL_NB = 4,
  parameter int TOTAL_BATCH_NB  = 2,
  parameter int TOTAL_PBS_NB    = 64,
  parameter int BATCH_PBS_NB    = 16,
  parameter int CMD_FIFO_DEPTH  = 4,
  localparam int BATCH_ID_W = (TOTAL_BATCH_NB > 1) ? $clog2(TOTAL_BATCH_NB) : 1,
  localparam int PID_W      = $clog2(TOTAL_PBS_NB),
  localparam int BPBS_ID_W  = $clog2(BATCH_PBS_NB),
  localparam int KS_LOOP_W  = (KS_BLOCK_COL_NB > 1) ? $clog2(KS_BLOCK_COL_NB) : 1
) (
  input  logic                      clk,
  input  logic                      a_rst,
  input  logic                      reset_cache,
  input  logic [BATCH_ID_W-1:0]     seq_cmd_batch_id,
  input  logic [PID_W-1:0]          seq_cmd_first_pid,
  input  logic [BPBS_ID_W-1:0]      seq_cmd_pbs_cnt_max,
  input  logic                      seq_cmd_vld,
  output logic                      seq_cmd_rdy,
  output logic [KS_LOOP_W-1:0]      feed_pcmd_ks_loop,
  output logic [BATCH_ID_W-1:0]     feed_pcmd_batch_id,
  output logic [TOTAL_BATCH_NB-1:0] feed_pcmd_batch_id_1h,
  output logic [PID_W-1:0]          feed_pcmd_first_pid,
  output logic [BPBS_ID_W-1:0]      feed_pcmd_pbs_cnt_max,
  output logic                      feed_vld,
  input  logic                      feed_rdy,
  output logic                      seq_ack,
  output logic [BATCH_ID_W-1:0]     seq_ack_batch_id
);

  localparam int DEPTH_W = $clog2(CMD_FIFO_DEPTH);
  localparam logic [KS_LOOP_W-1:0] KS_LAST = KS_LOOP_W'(KS_BLOCK_COL_NB - 1);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [BATCH_ID_W-1:0] batch_id;
    logic [PID_W-1:0]      first_pid;
    logic [BPBS_ID_W-1:0]  pbs_cnt_max;
  } cmd_t;

  state_e                    state_q, state_d;
  cmd_t                      mem_q [CMD_FIFO_DEPTH];
  logic [DEPTH_W:0]          wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic [DEPTH_W-1:0]        rd_idx, rd_idx_nxt;
  logic                      init_q, flush_q;
  logic                      fifo_empty, fifo_full;
  logic                      push, feed_hs, last_hs;
  cmd_t                      in_cmd, head_cmd, next_cmd, cmd_q, cmd_d;
  logic [KS_LOOP_W-1:0]      ks_loop_q, ks_loop_d;
  logic                      vld_q, vld_d;
  logic [TOTAL_BATCH_NB-1:0] batch_1h_q, batch_1h_d;
  logic                      ack_q;
  logic [BATCH_ID_W-1:0]     ack_id_q;

  assign in_cmd     = '{batch_id: seq_cmd_batch_id, first_pid: seq_cmd_first_pid,
                        pbs_cnt_max: seq_cmd_pbs_cnt_max};
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]) &&
                      (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]);
  assign rd_idx     = rd_ptr_q[DEPTH_W-1:0];
  assign rd_idx_nxt = rd_idx + DEPTH_W'(1);
  assign head_cmd   = mem_q[rd_idx];
  assign next_cmd   = mem_q[rd_idx_nxt];

  // init_q keeps ready low until the first edge after reset release.
  assign seq_cmd_rdy = init_q & ~fifo_full & ~flush_q;
  assign push        = seq_cmd_vld & seq_cmd_rdy;
  assign feed_hs     = vld_q & feed_rdy & ~flush_q;
  assign last_hs     = feed_hs & (ks_loop_q == KS_LAST);

  // The head stays in the FIFO while its columns are issued; it is popped
  // on the last-column handshake.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ks_loop_d = ks_loop_q;
    vld_d     = vld_q;
    if (flush_q) begin
      state_d   = IDLE;
      ks_loop_d = '0;
      vld_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty || push) begin
            // Empty FIFO: bypass the incoming command so it shows next cycle.
            cmd_d     = fifo_empty ? in_cmd : head_cmd;
            ks_loop_d = '0;
            vld_d     = 1'b1;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (last_hs) begin
            if (fifo_cnt > (DEPTH_W+1)'(1)) begin
              cmd_d     = next_cmd;
              ks_loop_d = '0;
            end else begin
              vld_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (feed_hs) begin
            ks_loop_d = ks_loop_q + KS_LOOP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign batch_1h_d = TOTAL_BATCH_NB'(1) << cmd_d.batch_id;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      flush_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_q      <= '0;
      ks_loop_q  <= '0;
      vld_q      <= 1'b0;
      batch_1h_q <= '0;
      ack_q      <= 1'b0;
      ack_id_q   <= '0;
      for (int i = 0; i < CMD_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      flush_q    <= reset_cache;
      cmd_q      <= cmd_d;
      ks_loop_q  <= ks_loop_d;
      vld_q      <= vld_d;
      batch_1h_q <= batch_1h_d;
      ack_q      <= last_hs;
      if (last_hs) ack_id_q <= cmd_q.batch_id;
      if (push) mem_q[wr_ptr_q[DEPTH_W-1:0]] <= in_cmd;
      if (flush_q) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)    wr_ptr_q <= wr_ptr_q + (DEPTH_W+1)'(1);
        if (last_hs) rd_ptr_q <= rd_ptr_q + (DEPTH_W+1)'(1);
      end
    end
  end

  assign feed_pcmd_ks_loop     = ks_loop_q;
  assign feed_pcmd_batch_id    = cmd_q.batch_id;
  assign feed_pcmd_batch_id_1h = batch_1h_q;
  assign feed_pcmd_first_pid   = cmd_q.first_pid;
  assign feed_pcmd_pbs_cnt_max = cmd_q.pbs_cnt_max;
  assign feed_vld              = vld_q;
  assign seq_ack               = ack_q;
  assign seq_ack_batch_id      = ack_id_q;

endmodule

// File: doc/pep_ks_ctrl_cmd_gen.md
Name: pep_ks_ctrl_cmd_gen

Overview:
- Sits directly upstream of the KS feed stage (pep_ks_ctrl_feed) and drives its ffifo_feed_pcmd/vld/rdy interface.
- Accepts one batch command per KS batch from the sequencer and buffers it in a small command FIFO.
- Expands each buffered command into KS_BLOCK_COL_NB per-column process commands (ks_loop = 0..KS_BLOCK_COL_NB-1), presented one at a time to the feed stage.
- Reports completion of each batch command back to the sequencer.

Parameters:
- KS_BLOCK_COL_NB, 4, number of KSK block columns (ks_loop iterations per command).
- TOTAL_BATCH_NB, 2, number of batch slots. BATCH_ID_W = max(1, clog2(TOTAL_BATCH_NB)).
- TOTAL_PBS_NB, 64, PID range. PID_W = clog2(TOTAL_PBS_NB).
- BATCH_PBS_NB, 16, max PBS per batch. BPBS_ID_W = clog2(BATCH_PBS_NB).
- CMD_FIFO_DEPTH, 4, command FIFO entries. Power of 2, at least 2.

Ports:
- clk  in  1  clock.
- a_rst  in  1  reset.
- reset_cache  in  1  synchronous flush request.
- seq_cmd_batch_id  in  BATCH_ID_W  batch slot of the incoming command.
- seq_cmd_first_pid  in  PID_W  first PID of the batch.
- seq_cmd_pbs_cnt_max  in  BPBS_ID_W  PBS count minus 1.
- seq_cmd_vld  in  1  command valid.
- seq_cmd_rdy  out  1  command ready.
- feed_pcmd_ks_loop  out  clog2(KS_BLOCK_COL_NB)  current column.
- feed_pcmd_batch_id  out  BATCH_ID_W  batch slot.
- feed_pcmd_batch_id_1h  out  TOTAL_BATCH_NB  one-hot of batch_id.
- feed_pcmd_first_pid  out  PID_W  first PID.
- feed_pcmd_pbs_cnt_max  out  BPBS_ID_W  PBS count minus 1.
- feed_vld  out  1  process command valid.
- feed_rdy  in  1  process command ready.
- seq_ack  out  1  pulse: all columns of one command handed to the feed stage.
- seq_ack_batch_id  out  BATCH_ID_W  batch slot of the acknowledged command.

Behaviour:
- Reset and clock: one clock, clk. a_rst is asynchronous, active-high; all state clears on assertion.
- Reset values: seq_cmd_rdy=0, feed_vld=0, seq_ack=0, all pcmd fields and seq_ack_batch_id = 0.
- seq_cmd_rdy rises the first cycle after a_rst deassertion.
- Input handshake:
  - A push occurs when seq_cmd_vld & seq_cmd_rdy.
  - seq_cmd_rdy = (fifo_count < CMD_FIFO_DEPTH) & ~flush_q, computed from registered state only.
  - No push is possible while the FIFO is full, even if a pop happens in the same cycle.
- Output stage:
  - All feed_* outputs are registers.
  - A command pushed in cycle N into an empty FIFO, with the output stage idle, shows feed_vld=1, ks_loop=0 in cycle N+1.
  - While feed_vld=1 and feed_rdy=0, every feed_pcmd_* field holds stable.
- Column counter (states IDLE/RUN):
  - IDLE, FIFO non-empty: load head, ks_loop=0, go to RUN.
  - RUN, feed_vld&feed_rdy with ks_loop < KS_BLOCK_COL_NB-1: ks_loop+1 next cycle.
  - RUN, feed_vld&feed_rdy with ks_loop == KS_BLOCK_COL_NB-1: pop head.
    - FIFO holds another command: present it with ks_loop=0 the next cycle (no bubble), stay in RUN.
    - Otherwise: feed_vld=0, go to IDLE.
  - Throughput is one process command per cycle under a continuous feed_rdy.
- batch_id_1h = 1 << batch_id, registered with the other fields.
- Ack: seq_ack=1 for exactly one cycle, the cycle after the last-column handshake; seq_ack_batch_id = that command's batch_id.
- FIFO pointers: DEPTH_W+1 bits with a wrap bit. Full when the index bits are equal and the wrap bits differ; empty when the pointers are equal. Push and pop in the same cycle leave fifo_count unchanged.
- Flush:
  - reset_cache is registered into flush_q.
  - When flush_q=1, the next edge clears the FIFO pointers, clears ks_loop, forces feed_vld=0, and forces the state to IDLE.
  - No seq_ack is issued for flushed commands.
  - A handshake in the same cycle as flush_q=1 is discarded.
- Wide state: first_pid, pbs_cnt_max and batch_id are passed through unchanged (no arithmetic). Only ks_loop increments, with wrap at KS_BLOCK_COL_NB-1.

Test Plan:
1. Single command, feed_rdy=1 constant.
   - Stimulus: push {batch 1, first_pid 60, pbs_cnt_max 7}.
   - Required: ks_loop 0,1,2,3 in cycles N+1..N+4, batch_id_1h=2'b10; seq_ack at N+5 with batch_id 1; feed_vld=0 at N+5.
2. Back-to-back, three commands pushed in consecutive cycles.
   - Required: 12 contiguous feed_vld cycles; three seq_ack pulses spaced 4 cycles apart.
3. Backpressure: feed_rdy toggled 0/1 randomly.
   - Required: fields stable whenever feed_vld=1 & feed_rdy=0; every column 0..3 seen exactly once per command.
4. Full FIFO with feed_rdy=0: push 5 commands.
   - Required: seq_cmd_rdy=0 after the 4th push; the 5th push is accepted only in the cycle after the first pop.
5. Flush: reset_cache pulse while in RUN at ks_loop 2, with 2 commands queued.
   - Required: feed_vld=0 within 2 cycles, no seq_ack, FIFO empty; a new push then restarts at ks_loop 0.
6. Asynchronous reset: a_rst asserted mid-RUN, between clock edges.
   - Required: feed_vld, seq_ack and seq_cmd_rdy go to 0 immediately; after release, behaviour matches scenario 1.
